// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI byte sequencer
package spi_pkg;

    localparam int SPI_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_EN,
        WAIT_DONE,
        CAPTURE
    } seq_state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// rtl/spi_sync_fifo.sv - first-word-fall-through synchronous FIFO, power-of-2 depth
module spi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Extra MSB distinguishes full from empty when the index bits match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count    = wr_ptr - rd_ptr;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // A pop frees the slot a simultaneous push lands in, so both proceed even when full.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/spi_byte_sequencer.sv
// rtl/spi_byte_sequencer.sv - TX/RX FIFO front end feeding one byte at a time to the SPI driver; SPI_SEQ_TIMEOUT_EN adds a WAIT_EN timeout
module spi_byte_sequencer
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int TX_DEPTH    = 4,
    parameter int RX_DEPTH    = 4
`ifdef SPI_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 64
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic [DATA_WIDTH-1:0] drv_data_in,
    output logic                  drv_start,
    input  logic                  drv_en,
    input  logic [DATA_WIDTH-1:0] drv_data_out,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int TXW = $clog2(TX_DEPTH) + 1;
    localparam int RXW = $clog2(RX_DEPTH) + 1;

    seq_state_t            state;
    logic [DATA_WIDTH-1:0] hold_reg;
    logic                  en_q;
    logic [DATA_WIDTH-1:0] tx_head;
    logic                  tx_empty;
    logic [TXW-1:0]        tx_count;
    logic                  rx_empty;
    logic [RXW-1:0]        rx_count;
    logic                  tx_push;
    logic                  rx_pop;
    logic                  rx_push;
    logic                  rx_has_slot;
    logic                  load;

    assign tx_ready = (tx_count != TXW'(TX_DEPTH));
    assign tx_push  = tx_valid && tx_ready;
    assign rx_valid = !rx_empty;
    assign rx_pop   = rx_valid && rx_ready;

    // The capture of the previous byte has already landed by the time IDLE is
    // re-entered, so rx_count already includes every byte in flight.
    assign rx_has_slot = (rx_count < RXW'(RX_DEPTH));
    assign load        = (state == IDLE) && !tx_empty && rx_has_slot;
    assign rx_push     = (state == CAPTURE);

    assign drv_data_in = hold_reg;
    assign busy        = (state != IDLE) || !tx_empty;

    spi_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (tx_data),
        .pop       (load),
        .pop_data  (tx_head),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    spi_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (drv_data_out),
        .pop       (rx_pop),
        .pop_data  (rx_data),
        .empty     (rx_empty),
        .count     (rx_count)
    );

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_err_q;
    assign timeout_err = tmo_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold_reg  <= '0;
            drv_start <= 1'b0;
            en_q      <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
            tmo_cnt   <= '0;
            tmo_err_q <= 1'b0;
`endif
        end else begin
            drv_start <= 1'b0;
            en_q      <= drv_en;
            case (state)
                IDLE: begin
                    if (load) begin
                        hold_reg  <= tx_head;
                        drv_start <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    // Forget any drv_en high left over from a foreign transfer.
                    en_q  <= 1'b0;
                    state <= WAIT_EN;
`ifdef SPI_SEQ_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                WAIT_EN: begin
                    if (drv_en) begin
                        state <= WAIT_DONE;
                    end
`ifdef SPI_SEQ_TIMEOUT_EN
                    else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        tmo_err_q <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                WAIT_DONE: begin
                    if (en_q && !drv_en) state <= CAPTURE;
                end
                CAPTURE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// tb/tb_spi_byte_sequencer.sv - directed bench for spi_byte_sequencer with an inverting loopback driver model
module tb_spi_byte_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] drv_data_in;
    logic       drv_start;
    logic       drv_en;
    logic [7:0] drv_data_out;
    logic       busy;
    logic       timeout_err;

    int vectors    = 0;
    int miscompares = 0;
    int starts     = 0;
    bit drv_hang   = 1'b0;

    always #5 clk = ~clk;

    spi_byte_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .drv_data_in  (drv_data_in),
        .drv_start    (drv_start),
        .drv_en       (drv_en),
        .drv_data_out (drv_data_out),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always @(posedge clk) begin
        if (drv_start) starts <= starts + 1;
    end

    // Driver model: en rises one cycle after start, falls 8 cycles later with data_out = ~data_in.
    initial begin
        int phase;
        phase = 0;
        drv_en = 1'b0;
        drv_data_out = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                drv_en = 1'b0;
                phase  = 0;
            end else if (phase == 0) begin
                if (drv_start && !drv_hang) phase = 1;
            end else begin
                phase++;
                if (phase == 2) drv_en = 1'b1;
                if (phase == 10) begin
                    drv_en       = 1'b0;
                    drv_data_out = ~drv_data_in;
                    phase        = 0;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic push_byte(input logic [7:0] b);
        int n;
        n = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        while (!tx_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL push_wait: tx_ready stayed 0 for byte %h", b);
        end
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic pop_byte(output logic [7:0] d);
        int n;
        n = 0;
        rx_ready = 1'b1;
        @(negedge clk);
        while (!rx_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!rx_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL pop_wait: rx_valid stayed 0");
        end
        d = rx_data;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        rx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (tx_ready !== 1'b1)       begin miscompares++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
        vectors++; if (rx_valid !== 1'b0)       begin miscompares++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        vectors++; if (drv_start !== 1'b0)      begin miscompares++; $display("FAIL reset_drv_start: got %b expected 0", drv_start); end
        vectors++; if (drv_data_in !== 8'h00)   begin miscompares++; $display("FAIL reset_drv_data_in: got %h expected 00", drv_data_in); end
        vectors++; if (busy !== 1'b0)           begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (timeout_err !== 1'b0)    begin miscompares++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single;
        int s0;
        int n;
        int bad;
        bit started;
        logic [7:0] d;
        s0 = starts;
        bad = 0;
        started = 1'b0;
        n = 0;
        push_byte(8'hA5);
        @(negedge clk);
        while (!rx_valid && n < 60) begin
            if (drv_start) started = 1'b1;
            if (started && drv_data_in !== 8'hA5) bad++;
            @(negedge clk);
            n++;
        end
        vectors++; if (rx_valid !== 1'b1)      begin miscompares++; $display("FAIL single_rx_valid: got %b expected 1", rx_valid); end
        vectors++; if (bad != 0)               begin miscompares++; $display("FAIL single_hold: %0d cycles drv_data_in differed from a5", bad); end
        vectors++; if (starts - s0 != 1)       begin miscompares++; $display("FAIL single_starts: got %0d expected 1", starts - s0); end
        vectors++; if (rx_data !== 8'h5A)      begin miscompares++; $display("FAIL single_rx_data: got %h expected 5a", rx_data); end
        @(posedge clk);
        #1;
        pop_byte(d);
        idle_cycles(2);
        @(negedge clk);
        vectors++; if (busy !== 1'b0)          begin miscompares++; $display("FAIL single_busy: got %b expected 0", busy); end
        vectors++; if (rx_valid !== 1'b0)      begin miscompares++; $display("FAIL single_rx_empty: got %b expected 0", rx_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_burst;
        int s0;
        logic [7:0] d;
        logic [7:0] exp_rx [4];
        exp_rx = '{8'hFE, 8'hFD, 8'hFC, 8'hFB};
        s0 = starts;
        rx_ready = 1'b0;
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        push_byte(8'h04);
        idle_cycles(70);
        vectors++; if (starts - s0 != 4)       begin miscompares++; $display("FAIL burst_starts: got %0d expected 4", starts - s0); end
        for (int i = 0; i < 4; i++) begin
            pop_byte(d);
            vectors++; if (d !== exp_rx[i])    begin miscompares++; $display("FAIL burst_rx%0d: got %h expected %h", i, d, exp_rx[i]); end
        end
        @(negedge clk);
        vectors++; if (rx_valid !== 1'b0)      begin miscompares++; $display("FAIL burst_rx_empty: got %b expected 0", rx_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure;
        int s0;
        logic [7:0] d;
        logic [7:0] exp_rx [8];
        exp_rx = '{8'hEE, 8'hED, 8'hEC, 8'hEB, 8'hEA, 8'hE9, 8'hE8, 8'hE7};
        s0 = starts;
        rx_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_byte(8'h11 + 8'(i));
        idle_cycles(80);
        vectors++; if (starts - s0 != 4)       begin miscompares++; $display("FAIL bp_starts4: got %0d expected 4", starts - s0); end
        push_byte(8'h17);
        push_byte(8'h18);
        @(negedge clk);
        vectors++; if (tx_ready !== 1'b0)      begin miscompares++; $display("FAIL bp_tx_full: got %b expected 0", tx_ready); end
        vectors++; if (busy !== 1'b1)          begin miscompares++; $display("FAIL bp_busy: got %b expected 1", busy); end
        @(posedge clk);
        #1;
        idle_cycles(30);
        vectors++; if (starts - s0 != 4)       begin miscompares++; $display("FAIL bp_stalled: got %0d expected 4", starts - s0); end
        for (int i = 0; i < 2; i++) begin
            pop_byte(d);
            vectors++; if (d !== exp_rx[i])    begin miscompares++; $display("FAIL bp_rx%0d: got %h expected %h", i, d, exp_rx[i]); end
        end
        idle_cycles(40);
        vectors++; if (starts - s0 != 6)       begin miscompares++; $display("FAIL bp_starts6: got %0d expected 6", starts - s0); end
        for (int i = 2; i < 8; i++) begin
            pop_byte(d);
            vectors++; if (d !== exp_rx[i])    begin miscompares++; $display("FAIL bp_rx%0d: got %h expected %h", i, d, exp_rx[i]); end
        end
        idle_cycles(3);
        @(negedge clk);
        vectors++; if (rx_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL bp_drain: rx_valid=%b busy=%b expected 0 0", rx_valid, busy); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_simultaneous;
        int s0;
        int n;
        logic [7:0] head;
        logic [7:0] d;
        logic [7:0] exp_rx [3];
        exp_rx = '{8'hDF, 8'hCF, 8'hBF};
        s0 = starts;
        rx_ready = 1'b0;
        push_byte(8'h10);
        push_byte(8'h20);
        push_byte(8'h30);
        push_byte(8'h40);
        n = 0;
        @(negedge clk);
        while ((starts - s0 < 4 || !drv_en) && n < 100) begin @(negedge clk); n++; end
        while (drv_en && n < 100) begin @(negedge clk); n++; end
        vectors++; if (n >= 100)               begin miscompares++; $display("FAIL simul_wait: 4th transfer not seen, starts=%0d", starts - s0); end
        @(posedge clk);
        #1;
        rx_ready = 1'b1;
        @(negedge clk);
        head = rx_data;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        vectors++; if (head !== 8'hEF)         begin miscompares++; $display("FAIL simul_head: got %h expected ef", head); end
        for (int i = 0; i < 3; i++) begin
            pop_byte(d);
            vectors++; if (d !== exp_rx[i])    begin miscompares++; $display("FAIL simul_rx%0d: got %h expected %h", i, d, exp_rx[i]); end
        end
        @(negedge clk);
        vectors++; if (rx_valid !== 1'b0)      begin miscompares++; $display("FAIL simul_count: rx_valid got %b expected 0 after 3 pops", rx_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        int n;
        logic [7:0] d;
        push_byte(8'h99);
        n = 0;
        @(negedge clk);
        while (!drv_en && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (tx_ready !== 1'b1)      begin miscompares++; $display("FAIL rstmid_tx_ready: got %b expected 1", tx_ready); end
        vectors++; if (rx_valid !== 1'b0)      begin miscompares++; $display("FAIL rstmid_rx_valid: got %b expected 0", rx_valid); end
        vectors++; if (drv_start !== 1'b0)     begin miscompares++; $display("FAIL rstmid_drv_start: got %b expected 0", drv_start); end
        vectors++; if (drv_data_in !== 8'h00)  begin miscompares++; $display("FAIL rstmid_drv_data_in: got %h expected 00", drv_data_in); end
        vectors++; if (busy !== 1'b0)          begin miscompares++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        push_byte(8'h3C);
        pop_byte(d);
        vectors++; if (d !== 8'hC3)            begin miscompares++; $display("FAIL rstmid_after: got %h expected c3", d); end
        @(negedge clk);
        vectors++; if (rx_valid !== 1'b0)      begin miscompares++; $display("FAIL rstmid_no_stale: rx_valid got %b expected 0", rx_valid); end
        @(posedge clk);
        #1;
    endtask

`ifdef SPI_SEQ_TIMEOUT_EN
    task automatic test_timeout;
        int n;
        drv_hang = 1'b1;
        push_byte(8'h77);
        n = 0;
        @(negedge clk);
        while (!drv_start && n < 20) begin @(negedge clk); n++; end
        vectors++; if (drv_start !== 1'b1)     begin miscompares++; $display("FAIL tmo_start: drv_start got %b expected 1", drv_start); end
        repeat (64) @(negedge clk);
        vectors++; if (timeout_err !== 1'b0)   begin miscompares++; $display("FAIL tmo_early: got %b expected 0", timeout_err); end
        @(negedge clk);
        vectors++; if (timeout_err !== 1'b1)   begin miscompares++; $display("FAIL tmo_set: got %b expected 1", timeout_err); end
        repeat (3) @(negedge clk);
        vectors++; if (rx_valid !== 1'b0)      begin miscompares++; $display("FAIL tmo_no_rx: rx_valid got %b expected 0", rx_valid); end
        vectors++; if (busy !== 1'b0)          begin miscompares++; $display("FAIL tmo_idle: busy got %b expected 0", busy); end
        vectors++; if (timeout_err !== 1'b1)   begin miscompares++; $display("FAIL tmo_sticky: got %b expected 1", timeout_err); end
        @(posedge clk);
        #1;
    endtask
`else
    task automatic test_no_timeout;
        idle_cycles(2);
        @(negedge clk);
        vectors++; if (timeout_err !== 1'b0)   begin miscompares++; $display("FAIL no_timeout: got %b expected 0", timeout_err); end
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_burst;
        test_backpressure;
        test_simultaneous;
        test_reset_mid;
`ifdef SPI_SEQ_TIMEOUT_EN
        test_timeout;
`else
        test_no_timeout;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
